// File: rtl/test_collector.sv
// ---------------------------------------------------------------------------
// test_collector
//
// Gathers the fail/finish pairs of NUM_TESTS test harnesses into one
// registered verdict, and bounds the run with a global cycle timeout.
//
// Sequence after reset: IDLE for exactly one clock, then RUN until either
// every harness has finished (completion) or the cycle counter reaches
// TIMEOUT, then DONE, which holds every output until the next reset.
//
// Input handshake: there is no valid/ready pair. A harness signals by
// holding t_finish[i] high (sticky, latched here) and pulsing or holding
// t_fail[i] high. A bit counts only when it is exactly 1; X/Z reads as 0.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : asynchronous, active-high; clears all state
//   t_fail         : fail output of each harness
//   t_finish       : finish output of each harness
//   fail           : run failed (harness fail or timeout); valid with finish
//   finish         : verdict is final
//   pass           : finish and not fail
//   timeout        : run ended by timeout
//   fail_count     : number of harnesses whose fail has been latched
//   finished_mask  : latched finish per harness
//   cycles         : clocks spent in RUN; frozen in DONE
//
// Debug: the FSM state is the internal signal `state` (type state_t).
// ---------------------------------------------------------------------------
module test_collector #(
    parameter int NUM_TESTS = 4,
    parameter int TIMEOUT   = 1000,
    parameter int CNT_W     = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_TESTS-1:0]               t_fail,
    input  logic [NUM_TESTS-1:0]               t_finish,
    output logic                               fail,
    output logic                               finish,
    output logic                               pass,
    output logic                               timeout,
    output logic [$clog2(NUM_TESTS+1)-1:0]     fail_count,
    output logic [NUM_TESTS-1:0]               finished_mask,
    output logic [CNT_W-1:0]                   cycles
);

    localparam int FC_W = $clog2(NUM_TESTS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;

    logic [NUM_TESTS-1:0] fail_latch;

    // Inputs reduced to "exactly 1"; undriven harness registers count as 0.
    logic [NUM_TESTS-1:0] fin_clean;
    logic [NUM_TESTS-1:0] fail_clean;

    // Values the RUN edge would commit.
    logic [NUM_TESTS-1:0] mask_next;
    logic [NUM_TESTS-1:0] fail_next;
    logic [CNT_W-1:0]     cycles_next;
    logic [FC_W-1:0]      count_next;
    logic                 all_done;
    logic                 hit_timeout;

    always_comb begin
        fin_clean  = '0;
        fail_clean = '0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            fin_clean[i]  = (t_finish[i] === 1'b1);
            fail_clean[i] = (t_fail[i] === 1'b1);
        end
    end

    always_comb begin
        mask_next   = finished_mask | fin_clean;
        fail_next   = fail_latch | fail_clean;
        cycles_next = cycles + CNT_W'(1);
        count_next  = '0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            count_next = count_next + FC_W'(fail_next[i]);
        end
        all_done    = &mask_next;
        // Checked against the incremented value so the edge that reaches
        // TIMEOUT is the one that ends the run; the counter never wraps.
        hit_timeout = (cycles_next == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            fail_latch    <= '0;
            finished_mask <= '0;
            fail_count    <= '0;
            cycles        <= '0;
            fail          <= 1'b0;
            finish        <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Inputs are ignored for this one clock.
                    state <= S_RUN;
                end

                S_RUN: begin
                    cycles        <= cycles_next;
                    finished_mask <= mask_next;
                    fail_latch    <= fail_next;
                    fail_count    <= count_next;
                    // Completion has priority over a timeout on the same edge.
                    if (all_done) begin
                        state   <= S_DONE;
                        finish  <= 1'b1;
                        fail    <= |fail_next;
                        pass    <= ~(|fail_next);
                        timeout <= 1'b0;
                    end else if (hit_timeout) begin
                        state   <= S_DONE;
                        finish  <= 1'b1;
                        fail    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Terminal: everything holds until reset.
                    state <= S_DONE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_collector.sv
// ---------------------------------------------------------------------------
// tb_test_collector
//
// Drives test_collector (NUM_TESTS=4, TIMEOUT=16) through directed and
// randomized runs. Each run is described by a per-harness schedule (first
// finish cycle, single fail pulse cycle, X-noise masks, optional fail flood
// and optional mid-run reset). The bits actually driven each RUN cycle are
// recorded, and the expected verdict for every observed cycle is derived
// from those records: the run ends at the latest first-finish time if that
// is within TIMEOUT, otherwise at TIMEOUT with a timeout verdict.
// ---------------------------------------------------------------------------
module tb_test_collector;

    localparam int N    = 4;
    localparam int T    = 16;
    localparam int KMAX = T + 3;
    localparam int BIG  = 100000;

    typedef struct packed {
        logic        finish;
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [2:0]  fc;
        logic [3:0]  mask;
        logic [31:0] cyc;
    } snap_t;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- DUT ----------------
    logic [N-1:0] t_fail;
    logic [N-1:0] t_finish;
    logic         fail;
    logic         finish;
    logic         pass;
    logic         timeout;
    logic [2:0]   fail_count;
    logic [N-1:0] finished_mask;
    logic [31:0]  cycles;

    test_collector #(
        .NUM_TESTS (N),
        .TIMEOUT   (T),
        .CNT_W     (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .t_fail        (t_fail),
        .t_finish      (t_finish),
        .fail          (fail),
        .finish        (finish),
        .pass          (pass),
        .timeout       (timeout),
        .fail_count    (fail_count),
        .finished_mask (finished_mask),
        .cycles        (cycles)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Run schedule (set before each run_case call).
    int         fin_at  [N];   // first RUN cycle finish is high (0 = never)
    int         fail_at [N];   // RUN cycle of a one-cycle fail pulse (0 = none)
    logic [N-1:0] xn_fin;      // non-asserted finish bits driven as X
    logic [N-1:0] xn_fail;     // non-asserted fail bits driven as X
    int         flood_from;    // from this RUN cycle: t_fail all ones (0 = off)
    int         abort_k;       // assert reset mid-cycle in this RUN cycle (0 = off)

    // What was actually sampled as asserted, per RUN cycle.
    logic [N-1:0] rec_fin  [0:KMAX];
    logic [N-1:0] rec_fail [0:KMAX];
    snap_t        obs      [0:KMAX];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic snap_t take_snap();
        snap_t s;
        s.finish  = finish;
        s.pass    = pass;
        s.fail    = fail;
        s.timeout = timeout;
        s.fc      = fail_count;
        s.mask    = finished_mask;
        s.cyc     = cycles;
        return s;
    endfunction

    task automatic check_cleared(input string tag);
        check_val({tag, ".finish"},  64'(finish),        64'd0);
        check_val({tag, ".pass"},    64'(pass),          64'd0);
        check_val({tag, ".fail"},    64'(fail),          64'd0);
        check_val({tag, ".timeout"}, 64'(timeout),       64'd0);
        check_val({tag, ".fc"},      64'(fail_count),    64'd0);
        check_val({tag, ".mask"},    64'(finished_mask), 64'd0);
        check_val({tag, ".cycles"},  64'(cycles),        64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset    = 1'b1;
        t_finish = N'($urandom_range(0, 15));
        t_fail   = N'($urandom_range(0, 15));
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cleared({tag, ".rst"});
        reset = 1'b0;
        // Garbage during the IDLE clock must be ignored.
        t_finish = N'($urandom_range(0, 15));
        t_fail   = N'($urandom_range(0, 15));
    endtask

    task automatic drive_cycle(input int k);
        logic [N-1:0] tf;
        logic [N-1:0] fl;
        for (int i = 0; i < N; i++) begin
            tf[i] = (fin_at[i] != 0 && k >= fin_at[i]) ? 1'b1 : (xn_fin[i] ? 1'bx : 1'b0);
            fl[i] = (fail_at[i] == k) ? 1'b1 : (xn_fail[i] ? 1'bx : 1'b0);
        end
        if (flood_from != 0 && k >= flood_from) begin
            fl = '1;
            tf = N'($urandom_range(0, 15));
        end
        t_finish = tf;
        t_fail   = fl;
        for (int i = 0; i < N; i++) begin
            rec_fin[k][i]  = (t_finish[i] === 1'b1);
            rec_fail[k][i] = (t_fail[i] === 1'b1);
        end
    endtask

    // Expected outputs after each RUN edge, from the recorded stimulus.
    task automatic compare_run(input string name, input int last_j);
        int         first_fin [N];
        int         all_k;
        int         done_k;
        logic       to;
        int         cyc;
        int         fc;
        logic [N-1:0] e_mask;
        logic       fin_now;
        logic       e_fail;
        for (int i = 0; i < N; i++) begin
            first_fin[i] = BIG;
            for (int k = KMAX; k >= 1; k--) begin
                if (rec_fin[k][i]) first_fin[i] = k;
            end
        end
        all_k = 0;
        for (int i = 0; i < N; i++) begin
            if (first_fin[i] > all_k) all_k = first_fin[i];
        end
        if (all_k <= T) begin
            done_k = all_k;
            to     = 1'b0;
        end else begin
            done_k = T;
            to     = 1'b1;
        end
        for (int j = 0; j <= last_j; j++) begin
            string tag;
            tag = $sformatf("%s.c%0d", name, j);
            cyc = (j < done_k) ? j : done_k;
            fc  = 0;
            for (int i = 0; i < N; i++) begin
                logic seen;
                e_mask[i] = (first_fin[i] <= cyc);
                seen = 1'b0;
                for (int k = 1; k <= cyc; k++) begin
                    if (rec_fail[k][i]) seen = 1'b1;
                end
                if (seen) fc++;
            end
            fin_now = (j >= done_k);
            e_fail  = fin_now && (to || fc > 0);
            check_val({tag, ".finish"},  64'(obs[j].finish),  64'(fin_now));
            check_val({tag, ".fail"},    64'(obs[j].fail),    64'(e_fail));
            check_val({tag, ".pass"},    64'(obs[j].pass),    64'(fin_now && !e_fail));
            check_val({tag, ".timeout"}, 64'(obs[j].timeout), 64'(fin_now && to));
            check_val({tag, ".fc"},      64'(obs[j].fc),      64'(fc));
            check_val({tag, ".mask"},    64'(obs[j].mask),    64'(e_mask));
            check_val({tag, ".cycles"},  64'(obs[j].cyc),     64'(cyc));
        end
    endtask

    task automatic run_case(input string name);
        for (int k = 0; k <= KMAX; k++) begin
            rec_fin[k]  = '0;
            rec_fail[k] = '0;
        end
        do_reset(name);
        for (int k = 1; k <= KMAX; k++) begin
            @(negedge clock);
            obs[k-1] = take_snap();
            drive_cycle(k);
            if (k == abort_k) begin
                // Asynchronous reset between edges: outputs clear at once.
                #2 reset = 1'b1;
                #1 check_cleared({name, ".async"});
                compare_run(name, k - 1);
                return;
            end
        end
        @(negedge clock);
        obs[KMAX] = take_snap();
        compare_run(name, KMAX);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            fin_at[i]  = 0;
            fail_at[i] = 0;
        end
        xn_fin     = '0;
        xn_fail    = '0;
        flood_from = 0;
        abort_k    = 0;
    endtask

    task automatic sched_all_pass();
        clear_sched();
        for (int i = 0; i < N; i++) fin_at[i] = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        t_fail   = '0;
        t_finish = '0;

        // All harnesses finish in the first RUN cycle, no fails.
        sched_all_pass();
        run_case("all_pass");

        // Staggered finishes, one fail pulse before its own finish.
        clear_sched();
        fin_at[0] = 2; fin_at[1] = 3; fin_at[2] = 5; fin_at[3] = 7;
        fail_at[2] = 4;
        run_case("stagger");

        // X on inputs, two harnesses never finish: timeout.
        clear_sched();
        fin_at[0] = 1; fin_at[1] = 1;
        xn_fin  = 4'b0100;
        xn_fail = 4'b1100;
        run_case("x_timeout");

        // Last finish arrives on the edge that reaches TIMEOUT.
        clear_sched();
        fin_at[0] = 1; fin_at[1] = 3; fin_at[2] = 8; fin_at[3] = T;
        run_case("race");

        // Reset during RUN cycle 5 with two finishes latched, then rerun.
        clear_sched();
        fin_at[0] = 1; fin_at[1] = 2;
        abort_k = 5;
        run_case("mid_reset");
        sched_all_pass();
        run_case("rerun");

        // DONE holds while t_fail floods afterwards.
        sched_all_pass();
        flood_from = 2;
        run_case("done_hold");

        // Randomized schedules.
        for (int r = 0; r < 30; r++) begin
            clear_sched();
            for (int i = 0; i < N; i++) begin
                fin_at[i]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T + 2));
                fail_at[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, T + 2));
            end
            xn_fin  = N'($urandom_range(0, 15));
            xn_fail = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) flood_from = int'($urandom_range(1, KMAX));
            run_case($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/test_collector.md
Name: test_collector

Overview:
- Result aggregator that sits directly downstream of the per-operation CI test harnesses, which each expose a `fail` and `finish` pair.
- Latches each harness's fail/finish, enforces a global cycle timeout, and produces one registered verdict for the top-level CI bench to poll and report.
- One instance gathers NUM_TESTS harnesses into a single pass/fail/finish triple.

Parameters:
- NUM_TESTS, 4: number of harnesses monitored; must be ≥1.
- TIMEOUT, 1000: cycles spent in RUN before an unfinished run is declared timed out; must be ≥2.
- CNT_W, 32: width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock, input, 1: single clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- t_fail, input, NUM_TESTS: bit i is the fail output of harness i.
- t_finish, input, NUM_TESTS: bit i is the finish output of harness i.
- fail, output, 1: run failed (any harness fail, or timeout); valid when finish=1.
- finish, output, 1: verdict final.
- pass, output, 1: finish and not fail.
- timeout, output, 1: run ended by timeout.
- fail_count, output, $clog2(NUM_TESTS+1): number of harnesses whose fail was latched.
- finished_mask, output, NUM_TESTS: latched finish per harness.
- cycles, output, CNT_W: cycles spent in RUN; frozen in DONE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, named `reset`; clock named `clock`. All outputs are registered.
- Reset values: every output 0, all latches 0, cycles 0, state IDLE.
- Input validity: harness regs are not reset, so inputs may be X/Z. A bit counts as asserted only when it is exactly 1; X/Z is treated as 0.
- IDLE: lasts exactly one clock after reset deasserts; inputs ignored. Transitions to RUN on the next edge.
- RUN, every edge:
  - cycles increments.
  - finished_mask |= t_finish.
  - fail latch |= t_fail.
  - fail_count = popcount of the updated fail latch.
- Fail latching: a fail bit is latched whether it arrives before, with, or after its own finish, as long as the state is RUN.
- Completion: if (finished_mask | t_finish) is all-ones in a RUN cycle, that edge moves to DONE.
  - Outputs set on that edge: finish=1; fail = any latched fail, including this cycle's t_fail; pass = !fail; timeout=0.
  - Latency: finish rises one edge after the cycle in which the last t_finish was sampled high.
- Timeout: if the RUN edge would make cycles == TIMEOUT and completion is not met, that edge moves to DONE.
  - Outputs set on that edge: finish=1, timeout=1, fail=1, pass=0.
- Simultaneous completion and timeout on the same edge: completion wins, so timeout=0 and fail reflects harness fails only.
- DONE: terminal. All inputs ignored, all outputs hold, and cycles stops counting. Only reset leaves DONE.
- Counter: cycles never wraps, because DONE is entered at TIMEOUT at the latest.
- Reset mid-run or in DONE: all state and outputs clear asynchronously, then the IDLE→RUN sequence restarts.
- fail_count width: $clog2(NUM_TESTS+1) bits, so the count never overflows.

Test Plan (NUM_TESTS=4, TIMEOUT=16 unless stated):
1. All pass: reset 2 cycles; t_fail=0; t_finish=4'b1111 from the 1st RUN cycle.
   - Next edge: finish=1, pass=1, fail=0, timeout=0, fail_count=0, finished_mask=4'hF, cycles=1.
2. Staggered finishes with one failure: t_finish bits rise in RUN cycles 2,3,5,7 and stay high; t_fail[2]=1 pulses for one cycle in RUN cycle 4.
   - finish rises after RUN cycle 7: fail=1, pass=0, fail_count=1, cycles=7.
3. X inputs and timeout: t_finish=4'b0X11, t_fail=4'bXX00 held.
   - At the 16th RUN edge: finish=1, timeout=1, fail=1, finished_mask=4'b0011, fail_count=0, cycles=16.
4. Race: last t_finish bit rises in the same cycle that reaches TIMEOUT.
   - finish=1, timeout=0, pass=1.
5. Reset mid-run: assert reset asynchronously between edges during RUN cycle 5 with 2 finishes latched.
   - All outputs read 0 before the next edge; after release, one IDLE cycle, then rerun of scenario 1 passes identically.
6. DONE hold: after scenario 1, toggle t_fail=4'hF for 10 cycles.
   - fail stays 0, pass stays 1, cycles stays 1.
